leiwand_rv32_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the leiwand_rv32 SoC memory bus (valid/ready/addr/wdata/wen/rdata). It shares the single bus, which fans out to internal RAM, CLINT and UART, between the CPU core (master 0) and a second master such as a DMA or debug port (master 1). Arbitration is round-robin. A bus-timeout watchdog completes transactions that target unmapped addresses, where no slave ever raises ready, with an error.

---
 rtl/leiwand_rv32_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_leiwand_rv32_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_bus_arbiter.sv
// rtl/leiwand_rv32_bus_arbiter.sv - two-master round-robin memory bus arbiter with timeout watchdog
`ifndef XLEN
`define XLEN 32
`endif

module leiwand_rv32_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_m0_valid,
  output logic                   o_m0_ready,
  input  logic [`XLEN-1:0]       i_m0_addr,
  input  logic [`XLEN-1:0]       i_m0_wdata,
  input  logic [`XLEN/8-1:0]     i_m0_wen,
  output logic [`XLEN-1:0]       o_m0_rdata,
  input  logic                   i_m1_valid,
  output logic                   o_m1_ready,
  input  logic [`XLEN-1:0]       i_m1_addr,
  input  logic [`XLEN-1:0]       i_m1_wdata,
  input  logic [`XLEN/8-1:0]     i_m1_wen,
  output logic [`XLEN-1:0]       o_m1_rdata,
  output logic                   o_s_valid,
  input  logic                   i_s_ready,
  output logic [`XLEN-1:0]       o_s_addr,
  output logic [`XLEN-1:0]       o_s_wdata,
  output logic [`XLEN/8-1:0]     o_s_wen,
  input  logic [`XLEN-1:0]       i_s_rdata,
  output logic [1:0]             o_grant,
  output logic                   o_err,
  output logic [`XLEN-1:0]       o_err_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  // Timeout fires when the counter has seen TIMEOUT_CYCLES-1 stalled cycles.
  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [15:0]        tcnt_q, tcnt_d;
  logic [`XLEN-1:0]   err_addr_q, err_addr_d;

  logic               sel;
  logic               sel_valid;
  logic [`XLEN-1:0]   sel_addr;
  logic [`XLEN-1:0]   sel_wdata;
  logic [`XLEN/8-1:0] sel_wen;
  logic               ack;
  logic [`XLEN-1:0]   ack_data;

  // Request mux from whichever master the current state points at.
  always_comb begin
    sel       = (state_q == GRANT1);
    sel_valid = sel ? i_m1_valid : i_m0_valid;
    sel_addr  = sel ? i_m1_addr  : i_m0_addr;
    sel_wdata = sel ? i_m1_wdata : i_m0_wdata;
    sel_wen   = sel ? i_m1_wen   : i_m0_wen;
  end

  // Next-state, round-robin pick, timeout watchdog and the combinational bus outputs.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    tcnt_d     = tcnt_q;
    err_addr_d = err_addr_q;
    o_s_valid  = 1'b0;
    o_s_addr   = '0;
    o_s_wdata  = '0;
    o_s_wen    = '0;
    o_err      = 1'b0;
    ack        = 1'b0;
    ack_data   = '0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        // On a tie the master that was not served last wins.
        if (i_m0_valid && (!i_m1_valid || last_q)) begin
          state_d = GRANT0;
        end else if (i_m1_valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        o_s_addr  = sel_addr;
        o_s_wdata = sel_wdata;
        o_s_wen   = sel_wen;
        if (!sel_valid) begin
          // Master abandoned its request: release the bus silently.
          state_d = IDLE;
          last_d  = sel;
        end else if (i_s_ready) begin
          // Slave ready beats a coinciding timeout.
          o_s_valid = 1'b1;
          ack       = 1'b1;
          ack_data  = i_s_rdata;
          state_d   = IDLE;
          last_d    = sel;
        end else if (tcnt_q == TCNT_LAST) begin
          // Unmapped address: complete with zero data and drop any write.
          ack        = 1'b1;
          o_err      = 1'b1;
          err_addr_d = sel_addr;
          state_d    = IDLE;
          last_d     = sel;
        end else begin
          o_s_valid = 1'b1;
          tcnt_d    = tcnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    o_m0_ready = ack && !sel;
    o_m1_ready = ack && sel;
    o_m0_rdata = (ack && !sel) ? ack_data : '0;
    o_m1_rdata = (ack && sel)  ? ack_data : '0;
  end

  // Arbiter state, fairness pointer, watchdog counter and error address.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      tcnt_q     <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      tcnt_q     <= tcnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign o_grant    = {state_q == GRANT1, state_q == GRANT0};
  assign o_err_addr = err_addr_q;

endmodule

// File: tb/tb_leiwand_rv32_bus_arbiter.sv
// tb/tb_leiwand_rv32_bus_arbiter.sv - scoreboard bench for leiwand_rv32_bus_arbiter
`ifndef XLEN
`define XLEN 32
`endif

module tb_leiwand_rv32_bus_arbiter;

  localparam int TO = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wen   [2];
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        o_m0_ready, o_m1_ready, o_s_valid, o_err;
  logic [31:0] o_m0_rdata, o_m1_rdata, o_s_addr, o_s_wdata, o_err_addr;
  logic [3:0]  o_s_wen;
  logic [1:0]  o_grant;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        hold_off = 1'b0;
  int          slave_lat = 1;
  int          age = -1;

  req_t        rq0[$], rq1[$];
  exp_t        sb0[$], sb1[$];
  int          rd0 = 0, rd1 = 0, sbr0 = 0, sbr1 = 0;
  int          start_cyc [2];
  logic        done_seen [2];
  logic [31:0] exp_err_addr = 32'h0;
  logic [1:0]  prev_rdy = 2'b00;
  int          served_m[$], served_cyc[$], served_lat[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  leiwand_rv32_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_m0_valid (m_valid[0]),
    .o_m0_ready (o_m0_ready),
    .i_m0_addr  (m_addr[0]),
    .i_m0_wdata (m_wdata[0]),
    .i_m0_wen   (m_wen[0]),
    .o_m0_rdata (o_m0_rdata),
    .i_m1_valid (m_valid[1]),
    .o_m1_ready (o_m1_ready),
    .i_m1_addr  (m_addr[1]),
    .i_m1_wdata (m_wdata[1]),
    .i_m1_wen   (m_wen[1]),
    .o_m1_rdata (o_m1_rdata),
    .o_s_valid  (o_s_valid),
    .i_s_ready  (s_ready),
    .o_s_addr   (o_s_addr),
    .o_s_wdata  (o_s_wdata),
    .o_s_wen    (o_s_wen),
    .i_s_rdata  (s_rdata),
    .o_grant    (o_grant),
    .o_err      (o_err),
    .o_err_addr (o_err_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sdata(input logic [31:0] a);
    return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : ~a;
  endfunction

  // Queue a request for master m and its expected completion.
  task automatic submit(input int m, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    req_t r;
    exp_t e;
    r.addr  = a;
    r.wdata = wd;
    r.wen   = we;
    e.err   = (a[31:28] == 4'h3) || (slave_lat >= TO);
    e.rdata = e.err ? 32'h0 : sdata(a);
    if (m == 0) begin
      rq0.push_back(r);
      sb0.push_back(e);
    end else begin
      rq1.push_back(r);
      sb1.push_back(e);
    end
  endtask

  // Master models: hold valid until ready, then fetch the next queued request.
  always @(posedge clk) begin : drv_p
    req_t r;
    #1;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_valid[m] = 1'b0;
        if (m == 0) rd0 = rq0.size(); else rd1 = rq1.size();
      end else begin
        if (m_valid[m] && done_seen[m]) m_valid[m] = 1'b0;
        if (!m_valid[m] && !hold_off &&
            ((m == 0 && rd0 < rq0.size()) || (m == 1 && rd1 < rq1.size()))) begin
          if (m == 0) begin r = rq0[rd0]; rd0++; end
          else        begin r = rq1[rd1]; rd1++; end
          m_addr[m]    = r.addr;
          m_wdata[m]   = r.wdata;
          m_wen[m]     = r.wen;
          m_valid[m]   = 1'b1;
          start_cyc[m] = cyc;
        end
      end
    end
  end

  // Slave model: answers slave_lat cycles after grant, never for 0x3xxxxxxx, noisy ready while idle.
  always @(posedge clk) begin : slv_p
    #2;
    if (o_grant == 2'b00) begin
      age     = -1;
      s_ready = 1'b1;
      s_rdata = 32'hBAD0_0000;
    end else begin
      age++;
      if (o_s_addr[31:28] != 4'h3 && age == slave_lat) begin
        s_ready = 1'b1;
        s_rdata = sdata(o_s_addr);
      end else begin
        s_ready = 1'b0;
        s_rdata = 32'hBAD0_0000 | 32'(age);
      end
    end
  end

  // Monitor: pops the scoreboard on each master ready and checks the bus every cycle.
  always @(negedge clk) begin : mon_p
    logic [1:0]  rdy;
    logic [31:0] rd;
    exp_t        e;
    int          g;
    rdy = {o_m1_ready, o_m0_ready};
    if (!rst_n) begin
      sbr0 = sb0.size();
      sbr1 = sb1.size();
      exp_err_addr = 32'h0;
      prev_rdy = 2'b00;
      done_seen[0] = 1'b0;
      done_seen[1] = 1'b0;
    end else begin
      check("err_addr", o_err_addr, exp_err_addr);
      if (prev_rdy != 2'b00) check("grant_idle_after_done", {30'b0, o_grant}, 32'h0);
      for (int m = 0; m < 2; m++) begin
        rd = (m == 1) ? o_m1_rdata : o_m0_rdata;
        done_seen[m] = rdy[m];
        if (rdy[m]) begin
          check("grant_at_ready", {30'b0, o_grant}, (m == 0) ? 32'd1 : 32'd2);
          if ((m == 0) ? (sbr0 < sb0.size()) : (sbr1 < sb1.size())) begin
            if (m == 0) begin e = sb0[sbr0]; sbr0++; end
            else        begin e = sb1[sbr1]; sbr1++; end
            check(m == 0 ? "m0_rdata" : "m1_rdata", rd, e.rdata);
            check("err_on_ready", {31'b0, o_err}, {31'b0, e.err});
            if (e.err) begin
              check("s_valid_on_timeout", {31'b0, o_s_valid}, 32'h0);
              exp_err_addr = m_addr[m];
            end
            served_m.push_back(m);
            served_cyc.push_back(cyc);
            served_lat.push_back(cyc - start_cyc[m]);
          end else begin
            check("unexpected_ready", {31'b0, rdy[m]}, 32'h0);
          end
        end else begin
          check("rdata_without_ready", rd, 32'h0);
        end
      end
      if (rdy == 2'b00) check("err_without_ready", {31'b0, o_err}, 32'h0);
      if (o_grant != 2'b00) begin
        g = o_grant[1] ? 1 : 0;
        check("s_addr", o_s_addr, m_addr[g]);
        check("s_wdata", o_s_wdata, m_wdata[g]);
        check("s_wen", {28'b0, o_s_wen}, {28'b0, m_wen[g]});
        if (rdy == 2'b00) check("s_valid_granted", {31'b0, o_s_valid}, {31'b0, m_valid[g]});
      end else begin
        check("s_valid_idle", {31'b0, o_s_valid}, 32'h0);
      end
      prev_rdy = rdy;
    end
  end

  task automatic drain(input int budget);
    int k = 0;
    while ((rd0 < rq0.size() || rd1 < rq1.size() || sbr0 < sb0.size() || sbr1 < sb1.size() ||
            m_valid[0] || m_valid[1]) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check("drain_timeout", sb0.size() + sb1.size() - sbr0 - sbr1, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog_p
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main_p
    int base;
    int k;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_grant", {30'b0, o_grant}, 32'h0);
    check("rst_s_valid", {31'b0, o_s_valid}, 32'h0);
    check("rst_m0_ready", {31'b0, o_m0_ready}, 32'h0);
    check("rst_m1_ready", {31'b0, o_m1_ready}, 32'h0);
    check("rst_err", {31'b0, o_err}, 32'h0);
    check("rst_err_addr", o_err_addr, 32'h0);
    @(posedge clk); #3; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read from m0: grant N+1, ready N+2, idle N+3
    base = served_m.size();
    submit(0, 32'h8000_0010, 32'h0, 4'h0);
    k = 0;
    @(negedge clk);
    while (!m_valid[0] && k < 10) begin @(negedge clk); k++; end
    check("p1_grant_n", {30'b0, o_grant}, 32'h0);
    check("p1_s_valid_n", {31'b0, o_s_valid}, 32'h0);
    @(negedge clk);
    check("p1_grant_n1", {30'b0, o_grant}, 32'h1);
    check("p1_s_valid_n1", {31'b0, o_s_valid}, 32'h1);
    @(negedge clk);
    check("p1_ready_n2", {31'b0, o_m0_ready}, 32'h1);
    check("p1_rdata_n2", o_m0_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("p1_grant_n3", {30'b0, o_grant}, 32'h0);
    drain(50);
    check("p1_served", served_m.size(), base + 1);
    if (served_m.size() > base) check("p1_latency", served_lat[base], 32'd2);

    // Round-robin: both masters saturate; last served was m0 so m1 leads
    base = served_m.size();
    hold_off = 1'b1;
    for (int i = 0; i < 4; i++) begin
      submit(0, 32'h8000_1000 + 32'(i * 4), 32'h0, 4'h0);
      submit(1, 32'h8000_2000 + 32'(i * 4), 32'h0, 4'h0);
    end
    @(negedge clk);
    hold_off = 1'b0;
    drain(100);
    check("rr_served", served_m.size(), base + 8);
    if (served_m.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check("rr_order", served_m[base + i], (i % 2 == 0) ? 32'd1 : 32'd0);
        if (i > 0) check("rr_period", served_cyc[base + i] - served_cyc[base + i - 1], 32'd3);
      end
    end

    // Timeout on unmapped address from m1, m0 queued behind it
    base = served_m.size();
    submit(1, 32'h3000_0000, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    submit(0, 32'h8000_0100, 32'h0, 4'h0);
    drain(100);
    check("to_served", served_m.size(), base + 2);
    if (served_m.size() >= base + 2) begin
      check("to_first_m1", served_m[base], 32'd1);
      check("to_latency", served_lat[base], 32'(TO));
      check("to_then_m0", served_m[base + 1], 32'd0);
    end
    check("to_err_addr", o_err_addr, 32'h3000_0000);

    // Slave ready on the very cycle the watchdog would fire
    base = served_m.size();
    slave_lat = TO - 1;
    submit(0, 32'h8000_0200, 32'h0, 4'h0);
    drain(100);
    slave_lat = 1;
    check("co_served", served_m.size(), base + 1);
    if (served_m.size() > base) check("co_latency", served_lat[base], 32'(TO));
    check("co_err_addr_held", o_err_addr, 32'h3000_0000);

    // Byte-lane write from m1 passes through unchanged
    base = served_m.size();
    submit(1, 32'h8000_0040, 32'h1234_5678, 4'b0100);
    drain(50);
    check("wr_served", served_m.size(), base + 1);
    if (served_m.size() > base) check("wr_master", served_m[base], 32'd1);

    // Asynchronous reset in the middle of a grant
    submit(0, 32'h3000_0010, 32'h0, 4'h0);
    k = 0;
    @(negedge clk);
    while (o_grant == 2'b00 && k < 20) begin @(negedge clk); k++; end
    check("rs_pre_grant", {30'b0, o_grant}, 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rs_s_valid", {31'b0, o_s_valid}, 32'h0);
    check("rs_grant", {30'b0, o_grant}, 32'h0);
    check("rs_m0_ready", {31'b0, o_m0_ready}, 32'h0);
    check("rs_m1_ready", {31'b0, o_m1_ready}, 32'h0);
    check("rs_m0_rdata", o_m0_rdata, 32'h0);
    check("rs_err_addr", o_err_addr, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    base = served_m.size();
    hold_off = 1'b1;
    submit(0, 32'h8000_0300, 32'h0, 4'h0);
    submit(1, 32'h8000_0304, 32'h0, 4'h0);
    @(negedge clk);
    hold_off = 1'b0;
    drain(50);
    check("rs_served", served_m.size(), base + 2);
    if (served_m.size() >= base + 2) begin
      check("rs_first_m0", served_m[base], 32'd0);
      check("rs_second_m1", served_m[base + 1], 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
